alu_arbiter: RTL and testbench

//  Shares one alu instance (op 000 add, 001 sub, 010 and, 011 or, 100 xor)

---
 rtl/alu_arbiter_if.sv | 30 +++
 rtl/alu_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response bus between the per-lane command sources and alu_arbiter.
// master = requester/consumer side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int W    = 4,
  parameter int NREQ = 2
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*3-1:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_y;
  logic              rsp_zero;
  logic              rsp_carry;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_carry
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters: arbitrate, execute one op, hold tagged result.
// Define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module alu_arbiter_alu #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] y,
  output logic         zero,
  output logic         carry
);
  logic [W:0] ext;

  // Add/sub run one bit wider so bit W is carry-out or borrow.
  always_comb begin
    ext = '0;
    case (op)
      3'b000:  ext = {1'b0, a} + {1'b0, b};
      3'b001:  ext = {1'b0, a} - {1'b0, b};
      3'b010:  ext = {1'b0, a & b};
      3'b011:  ext = {1'b0, a | b};
      3'b100:  ext = {1'b0, a ^ b};
      default: ext = '0;
    endcase
    y     = ext[W-1:0];
    carry = ext[W];
    zero  = (ext[W-1:0] == '0);
  end
endmodule

module alu_arbiter #(
  parameter int W    = 4,
  parameter int NREQ = 2,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_arbiter_if.slave    bus,
  output logic            busy,
  output logic [CNTW-1:0] op_count
);
  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  if (NREQ < 2 || NREQ > 8) begin : g_nreq_check
    $fatal(1, "alu_arbiter: NREQ must be in 2..8");
  end

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [W-1:0]    y_q, y_d;
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [W-1:0]    alu_y;
  logic            alu_zero;
  logic            alu_carry;
  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] gnt_vec;

  alu_arbiter_alu #(.W(W)) u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .y     (alu_y),
    .zero  (alu_zero),
    .carry (alu_carry)
  );

  // First valid lane at or after the search base, wrapping upward.
  always_comb begin
    int base;
    int j;
    gnt_found = 1'b0;
    gnt_idx   = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    base = 0;
`else
    base = int'(rr_q);
`endif
    for (int k = 0; k < NREQ; k++) begin
      j = base + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_found && bus.req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    id_d    = id_q;
    y_d     = y_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    gnt_vec = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          gnt_vec[gnt_idx] = rst_n;
          a_d     = bus.req_a[gnt_idx*W +: W];
          b_d     = bus.req_b[gnt_idx*W +: W];
          op_d    = bus.req_op[gnt_idx*3 +: 3];
          id_d    = gnt_idx;
`ifdef ALU_ARB_FIXED_PRIO_EN
          rr_d    = '0;
`else
          rr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
`endif
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        y_d     = alu_y;
        zero_d  = alu_zero;
        carry_d = alu_carry;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          cnt_d   = cnt_q + CNTW'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= '0;
      y_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready = gnt_vec;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_y     = y_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_carry = carry_q;
  assign busy          = (state_q != S_IDLE);
  assign op_count      = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (W=4, NREQ=2): vector table plus arbitration,
// backpressure and mid-operation reset sequences.
module tb_alu_arbiter;
  localparam int W    = 4;
  localparam int NREQ = 2;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            busy;
  logic [CNTW-1:0] op_count;
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;
  int              exp_cnt = 0;

  alu_arbiter_if #(.W(W), .NREQ(NREQ)) bus ();

  alu_arbiter #(.W(W), .NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         lane;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] y;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op);
    bus.req_a[lane*W +: W] = a;
    bus.req_b[lane*W +: W] = b;
    bus.req_op[lane*3 +: 3] = op;
  endtask

  // Samples at the falling edge until a ready bit appears; leaves time at that negedge.
  task automatic wait_grant(output int g, output logic [NREQ-1:0] rv, input int budget);
    g  = -1;
    rv = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        rv = bus.req_ready;
        g  = rv[1] ? 1 : 0;
        break;
      end
      tick();
    end
    if (g < 0) chk("grant_timeout", 0, 1);
  endtask

  task automatic reset_dut();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic do_op(input vec_t v);
    int              g;
    logic [NREQ-1:0] rv;
    tick();
    bus.rsp_ready = 1'b1;
    set_lane(v.lane, v.a, v.b, v.op);
    bus.req_valid = NREQ'(1 << v.lane);
    wait_grant(g, rv, 10);
    chk("vec_ready", 32'(rv), 32'(1 << v.lane));
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("vec_exec_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("vec_exec_busy", 32'(busy), 1);
    chk("vec_exec_ready", 32'(bus.req_ready), 0);
    tick();
    @(negedge clk);
    chk("vec_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("vec_id", 32'(bus.rsp_id), 32'(v.lane));
    chk("vec_y", 32'(bus.rsp_y), 32'(v.y));
    chk("vec_zero", 32'(bus.rsp_zero), 32'(v.z));
    chk("vec_carry", 32'(bus.rsp_carry), 32'(v.c));
    exp_cnt++;
    tick();
    @(negedge clk);
    chk("vec_done_valid", 32'(bus.rsp_valid), 0);
    chk("vec_done_busy", 32'(busy), 0);
    chk("vec_op_count", 32'(op_count), 32'(exp_cnt));
  endtask

  initial begin
    int              g;
    int              exp_g;
    int              last;
    logic [NREQ-1:0] rv;
    logic [3:0]      held_y;

    vt[0] = '{lane: 0, a: 4'd9,  b: 4'd8,  op: 3'b000, y: 4'd1,  z: 1'b0, c: 1'b1};
    vt[1] = '{lane: 1, a: 4'd3,  b: 4'd5,  op: 3'b001, y: 4'd14, z: 1'b0, c: 1'b1};
    vt[2] = '{lane: 1, a: 4'd5,  b: 4'd5,  op: 3'b001, y: 4'd0,  z: 1'b1, c: 1'b0};
    vt[3] = '{lane: 0, a: 4'd15, b: 4'd15, op: 3'b111, y: 4'd0,  z: 1'b1, c: 1'b0};
    vt[4] = '{lane: 0, a: 4'd10, b: 4'd10, op: 3'b100, y: 4'd0,  z: 1'b1, c: 1'b0};
    vt[5] = '{lane: 1, a: 4'd12, b: 4'd10, op: 3'b010, y: 4'd8,  z: 1'b0, c: 1'b0};
    vt[6] = '{lane: 0, a: 4'd12, b: 4'd3,  op: 3'b011, y: 4'd15, z: 1'b0, c: 1'b0};
    vt[7] = '{lane: 1, a: 4'd7,  b: 4'd8,  op: 3'b000, y: 4'd15, z: 1'b0, c: 1'b0};
    vt[8] = '{lane: 0, a: 4'd15, b: 4'd0,  op: 3'b001, y: 4'd15, z: 1'b0, c: 1'b0};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;

    // Reset state, with requests pending while reset is held.
    tick();
    tick();
    bus.req_valid = 2'b11;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_y", 32'(bus.rsp_y), 0);
    chk("rst_id", 32'(bus.rsp_id), 0);
    bus.req_valid = '0;
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) do_op(vt[i]);

    // Arbitration with both lanes held valid.
    reset_dut();
    set_lane(0, 4'd1, 4'd1, 3'b000);
    set_lane(1, 4'd2, 4'd2, 3'b000);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b11;
    last = 0;
    for (int n = 0; n < 4; n++) begin
      wait_grant(g, rv, 10);
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = n % 2;
`endif
      chk("arb_grant", 32'(g), 32'(exp_g));
      chk("arb_onehot", 32'(rv), 32'(1 << exp_g));
      if (n > 0) chk("arb_spacing", 32'(cyc - last), 3);
      last = cyc;
      tick();
    end
    bus.req_valid = '0;
    tick();
    tick();
    tick();
    @(negedge clk);
    exp_cnt += 4;
    chk("arb_op_count", 32'(op_count), 32'(exp_cnt));

    // Backpressure: response held for 5 cycles, no new grants.
    reset_dut();
    set_lane(0, 4'd2, 4'd3, 3'b000);
    set_lane(1, 4'd9, 4'd6, 3'b100);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b11;
    wait_grant(g, rv, 10);
    chk("bp_grant", 32'(g), 0);
    tick();
    tick();
    @(negedge clk);
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("bp_y", 32'(bus.rsp_y), 5);
    held_y = bus.rsp_y;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus.rsp_valid), 1);
      chk("bp_hold_y", 32'(bus.rsp_y), 32'(held_y));
      chk("bp_hold_id", 32'(bus.rsp_id), 0);
      chk("bp_hold_ready", 32'(bus.req_ready), 0);
      chk("bp_hold_busy", 32'(busy), 1);
      chk("bp_hold_count", 32'(op_count), 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    exp_cnt = 1;
    chk("bp_op_count", 32'(op_count), 32'(exp_cnt));
    chk("bp_idle_busy", 32'(busy), 0);
    chk("bp_idle_valid", 32'(bus.rsp_valid), 0);
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("bp_next_ready", 32'(bus.req_ready), 1);
`else
    chk("bp_next_ready", 32'(bus.req_ready), 2);
`endif
    bus.req_valid = '0;

    // Reset during EXEC after a lane-0 grant moved the pointer to lane 1.
    tick();
    set_lane(0, 4'd4, 4'd4, 3'b000);
    bus.req_valid = 2'b01;
    wait_grant(g, rv, 10);
    chk("mr_first_grant", 32'(g), 0);
    tick();
    bus.req_valid = 2'b11;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_ready_in_rst", 32'(bus.req_ready), 0);
    tick();
    @(negedge clk);
    chk("mr_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_op_count", 32'(op_count), 0);
    chk("mr_ready_held", 32'(bus.req_ready), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_grant_after_rst", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = '0;
    tick();
    @(negedge clk);
    chk("mr_rsp_after_rst", 32'(bus.rsp_valid), 1);
    chk("mr_y_after_rst", 32'(bus.rsp_y), 8);
    chk("mr_id_after_rst", 32'(bus.rsp_id), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
